// File: rtl/pipeline_sequencer_pkg.sv
// Shared definitions for the pipeline sequencer: FSM state encoding and
// default sizing of the cycle counter and halt drain window.
package pipeline_sequencer_pkg;

    localparam int NUM_BITS     = 5;
    localparam int LEN_CNT      = 32;
    localparam int DRAIN_CYCLES = 3;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RUN       = 3'd1,
        S_WAIT_STEP = 3'd2,
        S_STEP      = 3'd3,
        S_DRAIN     = 3'd4,
        S_HALTED    = 3'd5
    } seq_state_e;

endpackage

// File: rtl/pipeline_sequencer_if.sv
// Control bundle between the debug unit / stage latches (master) and the
// pipeline sequencer (slave).
interface pipeline_sequencer_if
    import pipeline_sequencer_pkg::*;
#(
    parameter int num_bits = NUM_BITS,
    parameter int len_cnt  = LEN_CNT
);
    logic                debug_mode;
    logic                run_req;
    logic                step_req;
    logic                id_ex_mem_read;
    logic [num_bits-1:0] id_ex_rt;
    logic [num_bits-1:0] if_id_rs;
    logic [num_bits-1:0] if_id_rt;
    logic                branch_taken;
    logic                halt_flag_e;

    logic                pc_enable;
    logic                if_id_write;
    logic                pipe_enable;
    logic                id_ex_bubble;
    logic                flush;
    logic                halted;
    logic [len_cnt-1:0]  cycle_count;

    modport master (
        output debug_mode, run_req, step_req, id_ex_mem_read, id_ex_rt,
               if_id_rs, if_id_rt, branch_taken, halt_flag_e,
        input  pc_enable, if_id_write, pipe_enable, id_ex_bubble, flush,
               halted, cycle_count
    );

    modport slave (
        input  debug_mode, run_req, step_req, id_ex_mem_read, id_ex_rt,
               if_id_rs, if_id_rt, branch_taken, halt_flag_e,
        output pc_enable, if_id_write, pipe_enable, id_ex_bubble, flush,
               halted, cycle_count
    );

endinterface

// File: rtl/pipeline_sequencer_hazard_detector.sv
// Combinational load-use detector: the decoding instruction reads the
// register a load in ID/EX is about to write. Register 0 never hazards.
module hazard_detector
    import pipeline_sequencer_pkg::*;
#(
    parameter int num_bits = NUM_BITS
) (
    input  logic                id_ex_mem_read_i,
    input  logic [num_bits-1:0] id_ex_rt_i,
    input  logic [num_bits-1:0] if_id_rs_i,
    input  logic [num_bits-1:0] if_id_rt_i,
    output logic                load_use_o
);

    assign load_use_o = id_ex_mem_read_i
                      && (id_ex_rt_i != '0)
                      && ((id_ex_rt_i == if_id_rs_i) || (id_ex_rt_i == if_id_rt_i));

endmodule

// File: rtl/pipeline_sequencer.sv
// Central pipeline controller: free-run / single-step sequencing, load-use
// stalls, branch flush and post-halt drain for the five-stage core.
module pipeline_sequencer
    import pipeline_sequencer_pkg::*;
#(
    parameter int num_bits     = NUM_BITS,
    parameter int len_cnt      = LEN_CNT,
    parameter int drain_cycles = DRAIN_CYCLES
) (
    input  logic                 clk,
    input  logic                 reset,
    pipeline_sequencer_if.slave  bus
);

    localparam int DW = (drain_cycles < 1) ? 1 : $clog2(drain_cycles + 1);

    seq_state_e         state_q, state_d;
    logic [DW-1:0]      drain_q, drain_d;
    logic [len_cnt-1:0] cycle_cnt_q, cycle_cnt_d;

    logic load_use;
    logic pc_en, ifid_wr, pipe_en, bubble, flush_o, halted_o;

    hazard_detector #(.num_bits(num_bits)) u_hazard (
        .id_ex_mem_read_i (bus.id_ex_mem_read),
        .id_ex_rt_i       (bus.id_ex_rt),
        .if_id_rs_i       (bus.if_id_rs),
        .if_id_rt_i       (bus.if_id_rt),
        .load_use_o       (load_use)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            drain_q     <= '0;
            cycle_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        drain_d  = drain_q;
        pc_en    = 1'b0;
        ifid_wr  = 1'b0;
        pipe_en  = 1'b0;
        bubble   = 1'b0;
        flush_o  = 1'b0;
        halted_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.run_req)
                    state_d = bus.debug_mode ? S_WAIT_STEP : S_RUN;
            end
            S_RUN, S_STEP: begin
                pipe_en = 1'b1;
                pc_en   = 1'b1;
                ifid_wr = 1'b1;
                // Halt outranks a branch, which in turn cancels any load-use stall.
                if (bus.halt_flag_e) begin
                    pc_en   = 1'b0;
                    ifid_wr = 1'b0;
                    state_d = S_DRAIN;
                    drain_d = DW'(drain_cycles);
                end else begin
                    if (bus.branch_taken) begin
                        flush_o = 1'b1;
                    end else if (load_use) begin
                        pc_en   = 1'b0;
                        ifid_wr = 1'b0;
                        bubble  = 1'b1;
                    end
                    if (state_q == S_STEP)
                        state_d = S_WAIT_STEP;
                end
            end
            S_WAIT_STEP: begin
                if (bus.step_req)
                    state_d = S_STEP;
            end
            S_DRAIN: begin
                pipe_en = 1'b1;
                flush_o = 1'b1;
                drain_d = (drain_q != '0) ? drain_q - DW'(1) : '0;
                if (drain_q <= DW'(1))
                    state_d = S_HALTED;
            end
            S_HALTED: begin
                halted_o = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        if (pipe_en && (cycle_cnt_q != {len_cnt{1'b1}}))
            cycle_cnt_d = cycle_cnt_q + len_cnt'(1);
    end

    assign bus.pc_enable    = pc_en;
    assign bus.if_id_write  = ifid_wr;
    assign bus.pipe_enable  = pipe_en;
    assign bus.id_ex_bubble = bubble;
    assign bus.flush        = flush_o;
    assign bus.halted       = halted_o;
    assign bus.cycle_count  = cycle_cnt_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Scoreboard bench for pipeline_sequencer: each driven cycle queues its
// expected outputs, a falling-edge monitor pops and compares them.
module tb_pipeline_sequencer;

    typedef struct packed {
        logic [5:0]  f;    // {pc_enable, if_id_write, pipe_enable, id_ex_bubble, flush, halted}
        logic [31:0] cnt;
    } exp_t;

    localparam logic [5:0] E_OFF   = 6'b000000;
    localparam logic [5:0] E_RUN   = 6'b111000;
    localparam logic [5:0] E_STALL = 6'b001100;
    localparam logic [5:0] E_BR    = 6'b111010;
    localparam logic [5:0] E_HLT   = 6'b001000;
    localparam logic [5:0] E_DRN   = 6'b001010;
    localparam logic [5:0] E_DONE  = 6'b000001;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb_q[$];
    logic [31:0] exp_cnt;

    always #5 clk = ~clk;

    pipeline_sequencer_if #(.num_bits(5), .len_cnt(32)) bus ();

    pipeline_sequencer #(.num_bits(5), .len_cnt(32), .drain_cycles(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".pc_enable"},    32'(bus.pc_enable),    32'd0);
        check({tag, ".if_id_write"},  32'(bus.if_id_write),  32'd0);
        check({tag, ".pipe_enable"},  32'(bus.pipe_enable),  32'd0);
        check({tag, ".id_ex_bubble"}, 32'(bus.id_ex_bubble), 32'd0);
        check({tag, ".flush"},        32'(bus.flush),        32'd0);
        check({tag, ".halted"},       32'(bus.halted),       32'd0);
        check({tag, ".cycle_count"},  bus.cycle_count,       32'd0);
    endtask

    // One clock cycle of stimulus plus its expected outputs.
    task automatic cyc(input logic rr, input logic sr, input logic br, input logic hl,
                       input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [5:0] ef);
        exp_t e;
        @(posedge clk);
        #1;
        bus.run_req        = rr;
        bus.step_req       = sr;
        bus.branch_taken   = br;
        bus.halt_flag_e    = hl;
        bus.id_ex_mem_read = mr;
        bus.id_ex_rt       = ert;
        bus.if_id_rs       = rs;
        bus.if_id_rt       = rt;
        e.f   = ef;
        e.cnt = exp_cnt;
        sb_q.push_back(e);
        if (ef[3] && exp_cnt != 32'hFFFF_FFFF)
            exp_cnt = exp_cnt + 32'd1;
    endtask

    task automatic nop(input logic [5:0] ef, input int n);
        for (int i = 0; i < n; i++)
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, ef);
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check("pc_enable",    32'(bus.pc_enable),    32'(e.f[5]));
            check("if_id_write",  32'(bus.if_id_write),  32'(e.f[4]));
            check("pipe_enable",  32'(bus.pipe_enable),  32'(e.f[3]));
            check("id_ex_bubble", 32'(bus.id_ex_bubble), 32'(e.f[2]));
            check("flush",        32'(bus.flush),        32'(e.f[1]));
            check("halted",       32'(bus.halted),       32'(e.f[0]));
            check("cycle_count",  bus.cycle_count,       e.cnt);
        end
    end

    initial begin
        reset              = 1'b1;
        bus.debug_mode     = 1'b0;
        bus.run_req        = 1'b0;
        bus.step_req       = 1'b0;
        bus.branch_taken   = 1'b0;
        bus.halt_flag_e    = 1'b0;
        bus.id_ex_mem_read = 1'b0;
        bus.id_ex_rt       = '0;
        bus.if_id_rs       = '0;
        bus.if_id_rt       = '0;
        exp_cnt            = 32'd0;

        repeat (2) @(posedge clk);
        #2;
        check_reset_outputs("reset");
        @(negedge clk);
        reset = 1'b0;

        // Free-run start, ten enabled cycles, then count observed as 10.
        cyc(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, E_OFF);
        nop(E_RUN, 10);

        // Load-use via rs and rt, register-0 and no-load cases, branch priority.
        cyc(0, 0, 0, 0, 1, 5'd8, 5'd8, 5'd3, E_STALL);
        cyc(0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, E_RUN);
        cyc(0, 0, 0, 0, 1, 5'd5, 5'd1, 5'd5, E_STALL);
        cyc(0, 0, 0, 0, 0, 5'd5, 5'd5, 5'd5, E_RUN);
        cyc(0, 0, 1, 0, 1, 5'd8, 5'd8, 5'd0, E_BR);
        cyc(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, E_BR);
        cyc(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, E_RUN);

        // Halt in RUN: three drain cycles, then halted with counter frozen.
        cyc(0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, E_HLT);
        nop(E_DRN, 3);
        cyc(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, E_DONE);
        nop(E_DONE, 2);

        @(negedge clk);
        #1 reset = 1'b1;
        #1 check_reset_outputs("reset_halted");
        @(posedge clk);
        #1 reset = 1'b0;
        exp_cnt = 32'd0;

        // Single-step mode: three spaced steps, second pulse in STEP ignored.
        bus.debug_mode = 1'b1;
        cyc(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, E_OFF);
        nop(E_OFF, 2);
        cyc(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, E_OFF);
        cyc(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, E_RUN);
        nop(E_OFF, 3);
        cyc(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, E_OFF);
        nop(E_RUN, 1);
        nop(E_OFF, 3);
        cyc(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, E_OFF);
        cyc(0, 0, 0, 0, 1, 5'd8, 5'd8, 5'd0, E_STALL);
        nop(E_OFF, 3);

        // Halt during STEP drains without further steps; reset lands mid-drain.
        cyc(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, E_OFF);
        cyc(0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, E_HLT);
        nop(E_DRN, 2);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check_reset_outputs("reset_drain");
        @(posedge clk);
        #1 reset = 1'b0;
        exp_cnt = 32'd0;
        nop(E_OFF, 2);

        @(negedge clk);
        #1 check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_sequencer.md
# pipeline_sequencer

Central pipeline controller for the five-stage MIPS core. Sequences the IF/ID, ID/EX, EX/MEM and MEM/WB latches: free-run versus single-step debug operation, load-use stall insertion, branch/jump flush, and orderly drain after a halt instruction. Sits beside the stage latches and drives their enable/flush inputs, including the `flush` input of the execute/memory latch.

## Interface
Parameters:
- `num_bits`, 5: register-index width.
- `len_cnt`, 32: cycle-counter width.
- `drain_cycles`, 3: cycles granted after halt in execute so older instructions retire.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high.
- `debug_mode` in 1: 1 = single-step, 0 = free-run; sampled only in IDLE.
- `run_req` in 1: start pulse from the debug unit.
- `step_req` in 1: one-cycle advance pulse, honoured in WAIT_STEP only.
- `id_ex_mem_read` in 1: instruction in ID/EX is a load.
- `id_ex_rt` in `num_bits`: load destination.
- `if_id_rs`, `if_id_rt` in `num_bits`: sources of the decoding instruction.
- `branch_taken` in 1: taken branch/jump resolved at EX/MEM output.
- `halt_flag_e` in 1: halt instruction present in execute.
- `pc_enable` out 1: PC may update.
- `if_id_write` out 1: IF/ID may capture.
- `pipe_enable` out 1: ID/EX, EX/MEM, MEM/WB may capture.
- `id_ex_bubble` out 1: load ID/EX with zero control.
- `flush` out 1: zero IF/ID, ID/EX, EX/MEM control fields.
- `halted` out 1: program finished.
- `cycle_count` out `len_cnt`: enabled-cycle counter.

## Operation
- States: IDLE, RUN, WAIT_STEP, STEP, DRAIN, HALTED.
- IDLE: all enables 0. `run_req`: `debug_mode`=0 -> RUN, 1 -> WAIT_STEP.
- RUN: `pipe_enable`=1 every cycle; `halt_flag_e` -> DRAIN.
- WAIT_STEP: enables 0; `step_req` -> STEP.
- STEP: exactly one cycle of `pipe_enable`=1, then WAIT_STEP; `halt_flag_e` during STEP -> DRAIN.
- DRAIN: `pc_enable`=0, `if_id_write`=0, `pipe_enable`=1, `flush`=1 to IF/ID only semantics (front end squashed); counter loads `drain_cycles`, decrements; at 0 -> HALTED. Drain runs free even in debug mode.
- HALTED: all enables 0, `halted`=1; left only by `reset`.
- Hazard (RUN/STEP only): load_use = `id_ex_mem_read` & `id_ex_rt`!=0 & (`id_ex_rt`==`if_id_rs` | `id_ex_rt`==`if_id_rt`). Then `pc_enable`=0, `if_id_write`=0, `id_ex_bubble`=1.
- Priority in an enabled cycle: halt > `branch_taken` (flush=1, pc_enable=1, hazard stall suppressed) > load_use.
- `step_req` outside WAIT_STEP and `run_req` outside IDLE ignored.
- `cycle_count` increments when `pipe_enable`=1; saturates at all-ones; frozen in HALTED.

## Timing
- State, drain counter, `cycle_count` update on rising `clk`; outputs decoded from state plus hazard inputs, stable before the falling edge at which stage latches capture.
- Reset values: state IDLE, all enables 0, `id_ex_bubble` 0, `flush` 0, `halted` 0, `cycle_count` 0.
- `run_req` at edge N -> `pipe_enable`=1 in cycle N+1.
- `step_req` at edge N -> `pipe_enable` high for cycle N+1 only; back-to-back `step_req` in STEP ignored.
- Load-use stall lasts one cycle (the bubble clears the ID/EX load flag).
- `flush` high exactly the cycles `branch_taken` is high while enabled.
- `halt_flag_e` at edge N -> DRAIN cycles N+1..N+`drain_cycles`, `halted`=1 from N+`drain_cycles`+1.
- Reset mid-DRAIN or mid-STEP -> IDLE immediately, counter cleared.

## Structure
- Shared package: state encoding constants (3-bit), `drain_cycles` default, `len_cnt`.
- One natural sub-module: `hazard_detector` (combinational load-use comparator); FSM, drain counter and cycle counter stay in this block.

## Test plan
- Reset, `run_req`, `debug_mode`=0 -> `pipe_enable`=1 from next cycle; after 10 cycles `cycle_count`=10.
- RUN, `id_ex_mem_read`=1, `id_ex_rt`=8, `if_id_rs`=8 -> one cycle `pc_enable`=0, `if_id_write`=0, `id_ex_bubble`=1; `id_ex_rt`=0 -> no stall.
- Load-use and `branch_taken` same cycle -> `flush`=1, `pc_enable`=1, `id_ex_bubble`=0.
- `debug_mode`=1, three `step_req` pulses spaced 5 cycles -> exactly 3 enabled cycles, `cycle_count`=3.
- `halt_flag_e` in RUN -> 3 cycles `pipe_enable`=1, `pc_enable`=0, then `halted`=1, counter frozen; `run_req` has no effect.
- `reset` asserted during DRAIN -> IDLE, all outputs at reset values asynchronously.
